load_store_unit: RTL and testbench

CPU-side initiator for the word-addressed data memory. It accepts load/store requests from the MIPS pipeline for the full MIPS sub-word set (LB, LBU, LH, LHU, LW, SB, SH, SW) and turns each into word-only memory transactions. Loads get sign or zero extension. Sub-word stores use a read-modify-write on the word, since the memory only supports whole-word LW/SW. It sits between the execute/memory stage and the data memory, and stalls the pipeline through a ready/valid handshake.

---
 rtl/mips_pkg.sv | 37 +++
 rtl/load_store_unit_if.sv | 31 +++
 rtl/lsu_align.sv | 60 ++++++
 rtl/load_store_unit.sv | 126 ++++++++++++
 tb/tb_load_store_unit.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS memory-op definitions for the load/store unit.
// Contents: opcodes, FSM state encoding, word width and opcode classification helpers.
package mips_pkg;

    localparam int WORD_W = 32;

    localparam logic [5:0] OP_NOP = 6'h00;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_MERGE  = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_subword_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH);
    endfunction

    function automatic logic is_known_op(input logic [5:0] op);
        return is_load(op) || is_subword_store(op) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response handshake and word-only data-memory bus of the load/store unit.
// slave = the unit itself; master = the pipeline plus data memory facing it.
interface load_store_unit_if;
    import mips_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [5:0]        req_op;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              resp_valid;
    logic [WORD_W-1:0] resp_rdata;
    logic              resp_err;
    logic [5:0]        mem_op;
    logic [WORD_W-1:0] mem_address;
    logic [WORD_W-1:0] mem_writevalue;
    logic [WORD_W-1:0] mem_readvalue;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, mem_readvalue,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_op, mem_address, mem_writevalue
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, mem_readvalue,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_op, mem_address, mem_writevalue
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: load extension, sub-word store merge and alignment check.
// The alignment check exists only when LSU_ALIGN_CHECK_EN is defined.
module lsu_align
    import mips_pkg::*;
(
    input  logic [5:0]        i_op,
    input  logic [1:0]        i_addr_lo,
    input  logic [WORD_W-1:0] i_word,
    input  logic [15:0]       i_wdata,
    output logic [WORD_W-1:0] o_load,
    output logic [WORD_W-1:0] o_merged,
    output logic              o_align_err
);

    logic [4:0]  w_byte_pos;
    logic [4:0]  w_half_pos;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Little-endian lanes; halfwords ignore address bit 0.
    assign w_byte_pos = {i_addr_lo, 3'b000};
    assign w_half_pos = {i_addr_lo[1], 4'b0000};
    assign w_byte     = i_word[w_byte_pos +: 8];
    assign w_half     = i_word[w_half_pos +: 16];

    always_comb begin
        o_load = '0;
        case (i_op)
            OP_LB:   o_load = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_load = {24'b0, w_byte};
            OP_LH:   o_load = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_load = {16'b0, w_half};
            OP_LW:   o_load = i_word;
            default: o_load = '0;
        endcase
    end

    always_comb begin
        o_merged = i_word;
        if (i_op == OP_SB) begin
            o_merged[w_byte_pos +: 8] = i_wdata[7:0];
        end else if (i_op == OP_SH) begin
            o_merged[w_half_pos +: 16] = i_wdata;
        end
    end

`ifdef LSU_ALIGN_CHECK_EN
    always_comb begin
        o_align_err = 1'b0;
        case (i_op)
            OP_LH, OP_LHU, OP_SH: o_align_err = i_addr_lo[0];
            OP_LW, OP_SW:         o_align_err = |i_addr_lo;
            default:              o_align_err = 1'b0;
        endcase
    end
`else
    assign o_align_err = 1'b0;
`endif

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: maps MIPS LB/LBU/LH/LHU/LW/SB/SH/SW onto word-only memory LW/SW, using a
// read-modify-write for SB/SH. Misalignment errors are reported only with LSU_ALIGN_CHECK_EN.
module load_store_unit
    import mips_pkg::*;
#(
    parameter logic [5:0] NOP_OP = OP_NOP
)(
    input logic              clock,
    input logic              reset,
    load_store_unit_if.slave bus
);

    logic [1:0]        r_state;
    logic [5:0]        r_op;
    logic [1:0]        r_addr_lo;
    logic [15:0]       r_wdata_lo;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [WORD_W-1:0] r_resp_rdata;
    logic [5:0]        r_mem_op;
    logic [WORD_W-1:0] r_mem_address;
    logic [WORD_W-1:0] r_mem_writevalue;

    logic              w_idle;
    logic [5:0]        w_op;
    logic [1:0]        w_addr_lo;
    logic [WORD_W-1:0] w_load;
    logic [WORD_W-1:0] w_merged;
    logic              w_align_err;
    logic              w_req_err;

    // In IDLE the lane logic screens the incoming request; afterwards it serves the captured one.
    assign w_idle    = (r_state == ST_IDLE);
    assign w_op      = w_idle ? bus.req_op : r_op;
    assign w_addr_lo = w_idle ? bus.req_addr[1:0] : r_addr_lo;
    assign w_req_err = !is_known_op(bus.req_op) || w_align_err;

    lsu_align u_align (
        .i_op        (w_op),
        .i_addr_lo   (w_addr_lo),
        .i_word      (bus.mem_readvalue),
        .i_wdata     (r_wdata_lo),
        .o_load      (w_load),
        .o_merged    (w_merged),
        .o_align_err (w_align_err)
    );

    // NOTE: state and every output update with <= so all outputs come straight from flops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_op             <= NOP_OP;
            r_addr_lo        <= '0;
            r_wdata_lo       <= '0;
            r_req_ready      <= 1'b1;
            r_resp_valid     <= 1'b0;
            r_resp_err       <= 1'b0;
            r_resp_rdata     <= '0;
            r_mem_op         <= NOP_OP;
            r_mem_address    <= '0;
            r_mem_writevalue <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_op        <= bus.req_op;
                        r_addr_lo   <= bus.req_addr[1:0];
                        r_wdata_lo  <= bus.req_wdata[15:0];
                        r_req_ready <= 1'b0;
                        if (w_req_err) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else begin
                            r_state       <= ST_ACCESS;
                            r_mem_op      <= (bus.req_op == OP_SW) ? OP_SW : OP_LW;
                            r_mem_address <= {bus.req_addr[WORD_W-1:2], 2'b00};
                            if (bus.req_op == OP_SW) begin
                                r_mem_writevalue <= bus.req_wdata;
                            end
                        end
                    end
                end
                ST_ACCESS: begin
                    if (is_subword_store(r_op)) begin
                        r_state          <= ST_MERGE;
                        r_mem_op         <= OP_SW;
                        r_mem_writevalue <= w_merged;
                    end else begin
                        r_state      <= ST_RESP;
                        r_mem_op     <= NOP_OP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= is_load(r_op) ? w_load : '0;
                    end
                end
                ST_MERGE: begin
                    r_state      <= ST_RESP;
                    r_mem_op     <= NOP_OP;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= '0;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= '0;
                    r_mem_op     <= NOP_OP;
                end
            endcase
        end
    end

    assign bus.req_ready      = r_req_ready;
    assign bus.resp_valid     = r_resp_valid;
    assign bus.resp_err       = r_resp_err;
    assign bus.resp_rdata     = r_resp_rdata;
    assign bus.mem_op         = r_mem_op;
    assign bus.mem_address    = r_mem_address;
    assign bus.mem_writevalue = r_mem_writevalue;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-level reference memory model, directed cases from
// the test plan, a mid-operation reset, then randomized traffic; a monitor checks every response.
module tb_load_store_unit;
    import mips_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nlw;
        int          nsw;
        int          acc_cyc;
    } exp_t;

    logic clock;
    logic reset;
    int   cyc;
    int   total;
    int   bad;

    load_store_unit_if bus();

    load_store_unit #(.NOP_OP(6'h00)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Word memory seen by the DUT, plus a byte-addressed reference copy for the model.
    logic [31:0] mem [64];
    logic [7:0]  ref_bytes [256];
    logic        bd_en;
    logic [5:0]  bd_idx;
    logic [31:0] bd_val;
    exp_t        exp_q [$];
    exp_t        mon_e;
    int          n_lw;
    int          n_sw;
    logic [5:0]  op_tab [10];

    assign bus.mem_readvalue = mem[bus.mem_address[7:2]];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (bd_en) begin
            mem[bd_idx] <= bd_val;
        end else if (bus.mem_op == OP_SW) begin
            mem[bus.mem_address[7:2]] <= bus.mem_writevalue;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: little-endian byte memory, sizes and extension from the opcode.
    task automatic model(input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, output exp_t e);
        int size;
        int a;
        bit sgn;
        bit ld;
        bit known;
        bit misaligned_is_err;
        logic [31:0] v;
        size = 4; sgn = 0; ld = 1; known = 1;
        case (op)
            OP_LB:   begin size = 1; sgn = 1; end
            OP_LBU:  size = 1;
            OP_LH:   begin size = 2; sgn = 1; end
            OP_LHU:  size = 2;
            OP_LW:   size = 4;
            OP_SB:   begin size = 1; ld = 0; end
            OP_SH:   begin size = 2; ld = 0; end
            OP_SW:   begin size = 4; ld = 0; end
            default: known = 0;
        endcase
`ifdef LSU_ALIGN_CHECK_EN
        misaligned_is_err = 1;
`else
        misaligned_is_err = 0;
`endif
        a = int'(addr[7:0]);
        e.rdata = '0; e.err = 1'b0; e.lat = 2; e.nlw = 0; e.nsw = 0; e.acc_cyc = 0;
        if (!known || (misaligned_is_err && (a % size) != 0)) begin
            e.err = 1'b1;
            e.lat = 1;
        end else begin
            a = a - (a % size);
            if (ld) begin
                v = '0;
                for (int i = 0; i < size; i++) v[8*i +: 8] = ref_bytes[a+i];
                if (sgn) for (int b = 8*size; b < 32; b++) v[b] = v[8*size-1];
                e.rdata = v;
                e.nlw = 1;
            end else begin
                for (int i = 0; i < size; i++) ref_bytes[a+i] = wdata[8*i +: 8];
                e.nsw = 1;
                if (size < 4) begin
                    e.nlw = 1;
                    e.lat = 3;
                end
            end
        end
    endtask

    // Monitor: pops one expectation per response and checks data, error, latency and memory ops.
    always @(negedge clock) begin
        if (reset) begin
            n_lw = 0;
            n_sw = 0;
        end else begin
            if (bus.mem_op == OP_LW) n_lw++;
            else if (bus.mem_op == OP_SW) n_sw++;
            if (bus.mem_op != OP_NOP) begin
                check("mem_addr_align", 32'(bus.mem_address[1:0]), 32'd0);
                check("mem_op_legal", 32'((bus.mem_op == OP_LW) || (bus.mem_op == OP_SW)), 32'd1);
            end
            if (bus.resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 32'(bus.resp_valid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("resp_rdata", bus.resp_rdata, mon_e.rdata);
                    check("resp_err", 32'(bus.resp_err), 32'(mon_e.err));
                    check("resp_latency", 32'(cyc - mon_e.acc_cyc), 32'(mon_e.lat));
                    check("mem_lw_count", 32'(n_lw), 32'(mon_e.nlw));
                    check("mem_sw_count", 32'(n_sw), 32'(mon_e.nsw));
                end
                n_lw = 0;
                n_sw = 0;
            end
        end
    end

    task automatic set_word(input int idx, input logic [31:0] val);
        @(negedge clock);
        bd_en = 1'b1; bd_idx = idx[5:0]; bd_val = val;
        @(negedge clock);
        bd_en = 1'b0;
        for (int k = 0; k < 4; k++) ref_bytes[4*idx+k] = val[8*k +: 8];
    endtask

    // Called at a negedge; returns at the negedge after the accept edge with req_valid still high.
    task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        int g;
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr; bus.req_wdata = wdata;
        g = 0;
        while (!bus.req_ready && g < 20) begin
            @(negedge clock);
            g++;
        end
        if (!bus.req_ready) begin
            check("accept_timeout", 32'(bus.req_ready), 32'd1);
            bus.req_valid = 1'b0;
        end else begin
            model(op, addr, wdata, e);
            e.acc_cyc = cyc;
            exp_q.push_back(e);
            @(negedge clock);
        end
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic drain();
        int g;
        bus.req_valid = 1'b0;
        g = 0;
        while (exp_q.size() > 0 && g < 50) begin
            @(negedge clock);
            g++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clock);
    endtask

    initial begin
        logic [31:0] addr;
        int          pick;
        total = 0; bad = 0; cyc = 0; n_lw = 0; n_sw = 0;
        reset = 1'b1; bd_en = 1'b0; bd_idx = '0; bd_val = '0;
        bus.req_valid = 1'b0; bus.req_op = OP_NOP; bus.req_addr = '0; bus.req_wdata = '0;
        op_tab = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW, 6'h22, 6'h00};

        for (int w = 0; w < 64; w++) set_word(w, $urandom);
        @(negedge clock);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_mem_op", 32'(bus.mem_op), 32'd0);
        check("rst_mem_address", bus.mem_address, 32'd0);
        check("rst_mem_writevalue", bus.mem_writevalue, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Directed cases around the word 0x8899AABB at 0x10.
        set_word(4, 32'h8899AABB);
        issue(OP_LB,  32'h11, 32'h0);
        issue(OP_LBU, 32'h13, 32'h0);
        issue(OP_LH,  32'h12, 32'h0);
        issue(OP_LHU, 32'h10, 32'h0);
        issue(OP_SB,  32'h12, 32'h00000055);
        issue(OP_SW,  32'h20, 32'hDEADBEEF);
        issue(OP_LW,  32'h20, 32'h0);
        issue(OP_LH,  32'h11, 32'h0);
        issue(6'h3F,  32'h10, 32'h0);
        drain();
        check("sb_merged_word", mem[4], 32'h8855AABB);
        check("sw_word", mem[8], 32'hDEADBEEF);

        // SH aborted by reset while its LW is on the bus: the word must stay intact.
        set_word(4, 32'h8899AABB);
        check("abort_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1; bus.req_op = OP_SH; bus.req_addr = 32'h10; bus.req_wdata = 32'h1234;
        @(negedge clock);
        bus.req_valid = 1'b0;
        check("abort_access_lw", 32'(bus.mem_op), 32'(OP_LW));
        reset = 1'b1;
        @(negedge clock);
        check("abort_mem_op_nop", 32'(bus.mem_op), 32'(OP_NOP));
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("abort_ready_after", 32'(bus.req_ready), 32'd1);
        check("abort_no_resp", 32'(bus.resp_valid), 32'd0);
        idle(5);
        check("abort_word_kept", mem[4], 32'h8899AABB);

        // Randomized traffic with occasional gaps.
        for (int n = 0; n < 250; n++) begin
            pick = int'($urandom_range(0, 9));
            addr = 32'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
                1: addr[0] = 1'b0;
                2, 3: addr[1:0] = 2'b00;
                default: ;
            endcase
            issue(op_tab[pick], addr, $urandom);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        drain();

        for (int w = 0; w < 64; w++) begin
            check("final_mem_word", mem[w],
                  {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
